// File: rtl/mul_arb_pkg.sv
// Shared constants, ID-width helper and the tag carried alongside the multiplier pipeline.
package mul_arb_pkg;

    localparam int DEF_NREQ = 4;
    localparam int DEF_W    = 8;
    // Tag ID field is sized for the largest supported requester count (8).
    localparam int TAG_ID_W = 3;

    function automatic int id_width(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    typedef struct packed {
        logic                vld;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

    localparam int TAG_W = $bits(tag_t);

endpackage

// File: rtl/mul_share_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past the last winner.
module rr_arbiter
    import mul_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ
) (
    input  logic [NREQ-1:0]           req_i,
    input  logic [id_width(NREQ)-1:0] ptr_i,
    output logic [NREQ-1:0]           gnt_o,
    output logic [id_width(NREQ)-1:0] gnt_id_o,
    output logic                      gnt_vld_o
);

    localparam int IDW = id_width(NREQ);

    int idx;

    always_comb begin
        gnt_o     = '0;
        gnt_id_o  = '0;
        gnt_vld_o = 1'b0;
        idx       = 0;
        for (int off = 1; off <= NREQ; off++) begin
            idx = int'(ptr_i) + off;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!gnt_vld_o && req_i[idx[IDW-1:0]]) begin
                gnt_vld_o            = 1'b1;
                gnt_o[idx[IDW-1:0]]  = 1'b1;
                gnt_id_o             = idx[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/mul_share_arbiter.sv
// Shares one external pipelined multiplier among NREQ requesters with ID-tagged responses.
// Optional PERF_CNT_EN adds per-requester saturating grant counters (perf_sel/perf_cnt).
module mul_share_arbiter
    import mul_arb_pkg::*;
#(
    parameter int NREQ    = DEF_NREQ,
    parameter int W       = DEF_W,
    parameter int MUL_LAT = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NREQ-1:0]              req_valid,
    output logic [NREQ-1:0]              req_ready,
    input  logic [NREQ*W-1:0]            req_a,
    input  logic [NREQ*W-1:0]            req_b,
    output logic [W-1:0]                 mul_a,
    output logic [W-1:0]                 mul_b,
    input  logic [2*W-1:0]               mul_p,
    output logic                         rsp_valid,
    output logic [id_width(NREQ)-1:0]    rsp_id,
    output logic [2*W-1:0]               rsp_p,
    output logic [id_width(MUL_LAT+2)-1:0] in_flight
`ifdef PERF_CNT_EN
    ,
    input  logic [id_width(NREQ)-1:0]    perf_sel,
    output logic [15:0]                  perf_cnt
`endif
);

    localparam int IDW = id_width(NREQ);
    localparam int IFW = id_width(MUL_LAT + 2);

    logic [IDW-1:0] ptr_q, ptr_d;
    logic [W-1:0]   opa_q, opa_d, opb_q, opb_d;
    logic [IFW-1:0] inflight_q, inflight_d;
    tag_t [MUL_LAT:0] tag_q;
    tag_t           tag0_d;

    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_id;
    logic            gnt_vld;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req_i     (req_valid),
        .ptr_i     (ptr_q),
        .gnt_o     (gnt),
        .gnt_id_o  (gnt_id),
        .gnt_vld_o (gnt_vld)
    );

    assign req_ready = gnt;

    always_comb begin
        ptr_d  = ptr_q;
        opa_d  = opa_q;
        opb_d  = opb_q;
        tag0_d = '{vld: gnt_vld, id: TAG_ID_W'(gnt_id)};
        if (gnt_vld) begin
            ptr_d = gnt_id;
            opa_d = req_a[gnt_id*W +: W];
            opb_d = req_b[gnt_id*W +: W];
        end
    end

    // Accept and retire in the same cycle cancel out.
    always_comb begin
        inflight_d = inflight_q;
        case ({gnt_vld, rsp_valid})
            2'b10:   inflight_d = inflight_q + IFW'(1);
            2'b01:   inflight_d = inflight_q - IFW'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q      <= IDW'(NREQ - 1);
            opa_q      <= '0;
            opb_q      <= '0;
            inflight_q <= '0;
            tag_q      <= '0;
        end else begin
            ptr_q      <= ptr_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            inflight_q <= inflight_d;
            tag_q[0]   <= tag0_d;
            for (int s = 1; s <= MUL_LAT; s++) tag_q[s] <= tag_q[s-1];
        end
    end

    assign mul_a     = opa_q;
    assign mul_b     = opb_q;
    // Last tag stage lines up with the product leaving the multiplier.
    assign rsp_valid = tag_q[MUL_LAT].vld;
    assign rsp_id    = tag_q[MUL_LAT].id[IDW-1:0];
    assign rsp_p     = mul_p;
    assign in_flight = inflight_q;

`ifdef PERF_CNT_EN
    logic [NREQ-1:0][15:0] perf_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_q <= '0;
        end else if (gnt_vld && perf_q[gnt_id] != 16'hFFFF) begin
            perf_q[gnt_id] <= perf_q[gnt_id] + 16'd1;
        end
    end

    always_comb begin
        perf_cnt = '0;
        if (int'(perf_sel) < NREQ) perf_cnt = perf_q[perf_sel];
    end
`endif

endmodule
